jpeg_byte_streamer: RTL and testbench

//  Transmit side of the decoder byte-input interface. Reads a JPEG file image from a synchronous

---
 rtl/jpeg_pkg.sv | 6 +
 rtl/jpeg_byte_streamer_if.sv | 11 +
 rtl/stream_fifo2.sv | 37 +++
 rtl/jpeg_byte_streamer.sv | 96 +++++++++
 tb/tb_jpeg_byte_streamer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: marker byte values and streamer state encoding shared across the decoder front end.
package jpeg_pkg;
    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] MARKER_EOI    = 8'hD9;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERROR} stream_state_t;
endpackage

// File: rtl/jpeg_byte_streamer_if.sv
// jpeg_byte_streamer_if: memory read port plus decoder byte stream of the streamer.
interface jpeg_byte_streamer_if #(parameter int ADDR_W = 16);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              parser_ready;
    modport master (output mem_rd_en, mem_addr, byte_out, byte_valid, input mem_rd_data, parser_ready);
    modport slave (input mem_rd_en, mem_addr, byte_out, byte_valid, output mem_rd_data, parser_ready);
endinterface

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry byte FIFO; the head is presented directly as the stream output.
module stream_fifo2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       valid,
    output logic [1:0] count
);
    logic [7:0] slot [2];
    logic wp, rp;
    assign dout = slot[rp];
    assign valid = count != 2'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            count <= '0;
        end else if (flush) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                slot[wp] <= din;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/jpeg_byte_streamer.sv
// jpeg_byte_streamer: streams a JPEG image from byte memory into the decoder until EOI or length,
// with a stall watchdog on the decoder handshake.
module jpeg_byte_streamer
    import jpeg_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 17,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     length,
    jpeg_byte_streamer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 eoi_seen,
    output logic                 stall_error,
    output logic [CNT_W-1:0]     bytes_sent
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    stream_state_t state, state_n;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0] len_q, read_count;
    logic [WD_W-1:0] wd;
    logic [1:0] fifo_count;
    logic rd_q, prev_ff, accept, xfer, stalled, eoi_hit, last, wd_fire;
    assign accept  = start && state != ST_RUN;
    assign xfer    = bus.byte_valid && bus.parser_ready;
    assign stalled = bus.byte_valid && !bus.parser_ready;
    assign eoi_hit = xfer && prev_ff && bus.byte_out == MARKER_EOI;
    assign last    = eoi_hit || (xfer && bytes_sent + CNT_W'(1) == len_q);
    assign wd_fire = state == ST_RUN && stalled && wd == WD_W'(TIMEOUT_CYC - 1);
    assign busy    = state == ST_RUN;
    // Credit counts the byte leaving this cycle so back-to-back reads sustain 1 byte/cycle.
    assign bus.mem_rd_en = state == ST_RUN && !last && !wd_fire && read_count < len_q &&
                           (2'(rd_q) + fifo_count - 2'(xfer)) < 2'd2;
    assign bus.mem_addr  = base_q + read_count[ADDR_W-1:0];
    stream_fifo2 u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rd_q && state == ST_RUN),
        .pop  (xfer),
        .flush(last || wd_fire),
        .din  (bus.mem_rd_data),
        .dout (bus.byte_out),
        .valid(bus.byte_valid),
        .count(fifo_count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (accept) state_n = length == '0 ? ST_DONE : ST_RUN;
        else if (wd_fire) state_n = ST_ERROR;
        else if (last) state_n = ST_DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q <= '0;
            read_count <= '0;
            wd <= '0;
            rd_q <= 1'b0;
            prev_ff <= 1'b0;
            done <= 1'b0;
            eoi_seen <= 1'b0;
            stall_error <= 1'b0;
            bytes_sent <= '0;
        end else begin
            rd_q <= bus.mem_rd_en;
            done <= (accept && length == '0) || last;
            wd <= (stalled && !accept) ? wd + WD_W'(1) : '0;
            if (accept) begin
                base_q <= base_addr;
                len_q <= length;
                read_count <= '0;
                prev_ff <= 1'b0;
                eoi_seen <= 1'b0;
                stall_error <= 1'b0;
                bytes_sent <= '0;
            end else begin
                if (bus.mem_rd_en) read_count <= read_count + CNT_W'(1);
                if (xfer) begin
                    bytes_sent <= bytes_sent + CNT_W'(1);
                    prev_ff <= bus.byte_out == MARKER_PREFIX;
                end
                if (eoi_hit) eoi_seen <= 1'b1;
                if (wd_fire) stall_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jpeg_byte_streamer.sv
// tb_jpeg_byte_streamer: directed and randomized runs of the streamer against a byte-level
// model of which bytes an image should deliver.
module tb_jpeg_byte_streamer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [16:0] length = '0;
    logic busy, done, eoi_seen, stall_error;
    logic [16:0] bytes_sent;
    logic [7:0] mem [0:65535];
    int reads = 0;
    int checks = 0;
    int errors = 0;

    jpeg_byte_streamer_if #(.ADDR_W(16)) bus ();

    jpeg_byte_streamer #(.ADDR_W(16), .CNT_W(17), .TIMEOUT_CYC(2000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .eoi_seen   (eoi_seen),
        .stall_error(stall_error),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= mem[bus.mem_addr];
            reads++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) mem[16'(a + 16'(i))] = bytes[8*(n-1-i) +: 8];
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 random ready, 3 ready held low (watchdog)
    task automatic run(input logic [15:0] base, input int len, input int mode);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] b, hold_b;
        logic exp_eoi, hold_v, rdy;
        int k, first_k, done_k, stalls, r0;
        exp_eoi = 1'b0;
        for (int i = 0; i < len; i++) begin
            b = mem[16'(base + 16'(i))];
            exp_q.push_back(b);
            if (i > 0 && exp_q[i-1] == 8'hFF && b == 8'hD9) begin
                exp_eoi = 1'b1;
                break;
            end
        end
        r0 = reads;
        base_addr = base;
        length = 17'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, len > 0);
        k = 1; first_k = 0; done_k = 0; stalls = 0; hold_v = 1'b0; hold_b = '0;
        forever begin
            if (hold_v && !stall_error) begin
                check("hold_valid", bus.byte_valid, 1);
                check("hold_byte", bus.byte_out, hold_b);
            end
            if (bus.byte_valid && first_k == 0) first_k = k;
            if (done) done_k = k;
            if (done || stall_error || k >= 2500) break;
            rdy = mode == 0 ? 1'b1 : mode == 1 ? k[0] : mode == 2 ? 1'($urandom) : 1'b0;
            bus.parser_ready = rdy;
            hold_v = bus.byte_valid && !rdy;
            hold_b = bus.byte_out;
            if (bus.byte_valid && rdy) got_q.push_back(bus.byte_out);
            if (hold_v) stalls++;
            @(posedge clk); #1;
            k++;
        end
        check("run_finished", done || stall_error, 1);
        if (mode == 3) begin
            check("stall_error", stall_error, 1);
            check("stall_cycles", stalls, 2000);
            check("stall_valid_low", bus.byte_valid, 0);
            check("stall_busy_low", busy, 0);
            check("stall_no_done", done_k, 0);
        end else begin
            check("done_seen", done_k > 0, 1);
            check("byte_count", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("byte[%0d]", i), got_q[i], exp_q[i]);
            check("bytes_sent", bytes_sent, exp_q.size());
            check("eoi_seen", eoi_seen, exp_eoi);
            check("no_stall", stall_error, 0);
            check("busy_done", busy, 0);
            check("valid_flushed", bus.byte_valid, 0);
            check("reads_bounded", (reads - r0) <= len, 1);
            if (len > 0) check("first_valid_latency", first_k, 3);
            if (mode == 0) check("done_cycle", done_k, len == 0 ? 1 : exp_q.size() + 3);
        end
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);
    endtask

    initial begin
        logic [15:0] rb;
        int rl, r;
        bus.parser_ready = 1'b0;
        bus.mem_rd_data = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", bus.byte_valid, 0);
        check("rst_rd_en", bus.mem_rd_en, 0);
        check("rst_flags", {eoi_seen, stall_error}, 0);
        check("rst_bytes_sent", bytes_sent, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        put(16'h0100, 64'hFFD812FFD9AA, 6);
        run(16'h0100, 100, 0);
        run(16'h0100, 100, 1);
        put(16'h0200, 64'h01020304, 4);
        run(16'h0200, 3, 0);
        put(16'h0300, 64'hFFFFD9, 3);
        run(16'h0300, 100, 0);
        put(16'h0400, 64'hFF00D9FFD9, 5);
        run(16'h0400, 100, 2);
        put(16'h0500, 64'hFFD9, 2);
        run(16'h0500, 2, 0);
        put(16'hFFFC, 64'h0102030405060708, 8);
        run(16'hFFFC, 8, 2);
        run(16'h0100, 100, 3);
        run(16'h0100, 100, 0);
        for (int t = 0; t < 6; t++) begin
            rb = 16'($urandom);
            rl = $urandom_range(40, 1);
            for (int i = 0; i < rl; i++) begin
                r = $urandom_range(7, 0);
                mem[16'(rb + 16'(i))] = r < 2 ? 8'hFF : r == 2 ? 8'hD9 : 8'($urandom);
            end
            run(rb, rl, t % 3);
        end
        for (int i = 0; i < 64; i++) mem[16'h0600 + 16'(i)] = 8'(i);
        base_addr = 16'h0600;
        length = 17'd64;
        bus.parser_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && bytes_sent != 17'd2; i++) begin
            @(posedge clk); #1;
        end
        check("t6_mid_run", bytes_sent, 2);
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_valid", bus.byte_valid, 0);
        check("t6_rd_en", bus.mem_rd_en, 0);
        check("t6_bytes_sent", bytes_sent, 0);
        check("t6_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(16'h0600, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
